// File: rtl/c2f_chunk_sink.sv
// CPU->FPGA chunk sink: byte-masked chunked RAM filled by host writes, drained in order over valid/ready.
// Optional `C2F_SINK_OVERFLOW_EN adds a sticky overflowErr_out for writes into already-full chunks.
module c2f_chunk_sink #(
    parameter int CHUNK_WIDTH  = 2,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic                    pcieClk_in,
    input  logic                    pcieRstN_in,
    input  logic [CHUNK_WIDTH-1:0]  c2fChunkIndex_in,
    input  logic [OFFSET_WIDTH-1:0] c2fChunkOffset_in,
    input  logic [63:0]             c2fData_in,
    input  logic [7:0]              c2fBE_in,
    input  logic                    c2fValid_in,
    output logic [63:0]             chunkData_out,
    output logic                    chunkValid_out,
    input  logic                    chunkReady_in,
    output logic                    chunkLast_out,
    output logic [CHUNK_WIDTH-1:0]  rdChunk_out,
    output logic [CHUNK_WIDTH:0]    freeCount_out
`ifdef C2F_SINK_OVERFLOW_EN
    ,
    output logic                    overflowErr_out
`endif
);

    localparam int ADDR_WIDTH = CHUNK_WIDTH + OFFSET_WIDTH;
    localparam int NUM_CHUNKS = 1 << CHUNK_WIDTH;

    typedef enum logic [1:0] {S_WAIT, S_FETCH, S_STREAM} state_t;

    state_t                  state, stateNext;
    logic [CHUNK_WIDTH-1:0]  rdChunk, rdChunkNext, nextChunk;
    logic [OFFSET_WIDTH-1:0] rdOff, rdOffNext;
    logic [ADDR_WIDTH-1:0]   rdAddr;
    logic [NUM_CHUNKS-1:0]   full, fullNext, setFull, clearFull;
    logic [CHUNK_WIDTH:0]    freeCount, freeNext;
    logic [63:0]             ramQ;
    logic [63:0]             ram [2**ADDR_WIDTH];

    // NOTE: the RAM has no reset; its contents are meaningless until a chunk is marked full.
    always_ff @(posedge pcieClk_in) begin
        if (c2fValid_in) begin
            for (int b = 0; b < 8; b++) begin
                if (c2fBE_in[b])
                    ram[{c2fChunkIndex_in, c2fChunkOffset_in}][8*b +: 8] <= c2fData_in[8*b +: 8];
            end
        end
        ramQ <= ram[rdAddr];
    end

    assign nextChunk = rdChunk + 1'b1;

    // NOTE: every signal driven here gets a default first so no latch can be inferred.
    always_comb begin
        stateNext   = state;
        rdChunkNext = rdChunk;
        rdOffNext   = rdOff;
        clearFull   = '0;
        case (state)
            S_WAIT: begin
                rdOffNext = '0;
                if (full[rdChunk])
                    stateNext = S_FETCH;
            end
            S_FETCH: stateNext = S_STREAM;
            S_STREAM: begin
                if (chunkReady_in) begin
                    if (&rdOff) begin
                        clearFull[rdChunk] = 1'b1;
                        rdChunkNext        = nextChunk;
                        rdOffNext          = '0;
                        stateNext          = full[nextChunk] ? S_FETCH : S_WAIT;
                    end else begin
                        rdOffNext = rdOff + 1'b1;
                    end
                end
            end
            default: stateNext = S_WAIT;
        endcase
        // Reading the next address combinationally keeps the stream at one QW per clock.
        rdAddr = {rdChunkNext, rdOffNext};
    end

    always_comb begin
        setFull = '0;
        if (c2fValid_in && (&c2fChunkOffset_in))
            setFull[c2fChunkIndex_in] = 1'b1;
        fullNext = (full & ~clearFull) | setFull;
        freeNext = '0;
        for (int i = 0; i < NUM_CHUNKS; i++)
            freeNext = freeNext + {{CHUNK_WIDTH{1'b0}}, ~fullNext[i]};
    end

    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in) begin
            state     <= S_WAIT;
            rdChunk   <= '0;
            rdOff     <= '0;
            full      <= '0;
            freeCount <= (CHUNK_WIDTH+1)'(NUM_CHUNKS);
        end else begin
            state     <= stateNext;
            rdChunk   <= rdChunkNext;
            rdOff     <= rdOffNext;
            full      <= fullNext;
            freeCount <= freeNext;
        end
    end

`ifdef C2F_SINK_OVERFLOW_EN
    logic overflowErr;

    always_ff @(posedge pcieClk_in or negedge pcieRstN_in) begin
        if (!pcieRstN_in)
            overflowErr <= 1'b0;
        else if (c2fValid_in && full[c2fChunkIndex_in])
            overflowErr <= 1'b1;
    end

    assign overflowErr_out = overflowErr;
`endif

    assign chunkData_out  = ramQ;
    assign chunkValid_out = (state == S_STREAM);
    assign chunkLast_out  = (state == S_STREAM) && (&rdOff);
    assign rdChunk_out    = rdChunk;
    assign freeCount_out  = freeCount;

endmodule

// File: tb/tb_c2f_chunk_sink.sv
// Directed bench for c2f_chunk_sink: in-order drain, byte masking, backpressure,
// out-of-order fill, mid-stream reset and (with C2F_SINK_OVERFLOW_EN) overflow flag.
module tb_c2f_chunk_sink;

    localparam int CW = 2;
    localparam int OW = 4;

    logic          pcieClk = 1'b0;
    logic          pcieRstN = 1'b0;
    logic [CW-1:0] c2fChunkIndex = '0;
    logic [OW-1:0] c2fChunkOffset = '0;
    logic [63:0]   c2fData = '0;
    logic [7:0]    c2fBE = '0;
    logic          c2fValid = 1'b0;
    logic [63:0]   chunkData;
    logic          chunkValid;
    logic          chunkReady = 1'b1;
    logic          chunkLast;
    logic [CW-1:0] rdChunk;
    logic [CW:0]   freeCount;
`ifdef C2F_SINK_OVERFLOW_EN
    logic          overflowErr;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    logic [63:0] expData [16];

    c2f_chunk_sink #(.CHUNK_WIDTH(CW), .OFFSET_WIDTH(OW)) dut (
        .pcieClk_in       (pcieClk),
        .pcieRstN_in      (pcieRstN),
        .c2fChunkIndex_in (c2fChunkIndex),
        .c2fChunkOffset_in(c2fChunkOffset),
        .c2fData_in       (c2fData),
        .c2fBE_in         (c2fBE),
        .c2fValid_in      (c2fValid),
        .chunkData_out    (chunkData),
        .chunkValid_out   (chunkValid),
        .chunkReady_in    (chunkReady),
        .chunkLast_out    (chunkLast),
        .rdChunk_out      (rdChunk),
        .freeCount_out    (freeCount)
`ifdef C2F_SINK_OVERFLOW_EN
        ,
        .overflowErr_out  (overflowErr)
`endif
    );

    always #4 pcieClk = ~pcieClk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        testsRun++;
        if (got !== want) begin
            testsFailed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Called at a negedge; the following posedge captures the write.
    task automatic writeQw(input int chunk, input int off, input logic [63:0] data, input logic [7:0] be);
        c2fChunkIndex  = CW'(chunk);
        c2fChunkOffset = OW'(off);
        c2fData        = data;
        c2fBE          = be;
        c2fValid       = 1'b1;
        @(negedge pcieClk);
        c2fValid       = 1'b0;
    endtask

    // Receives one 16-beat chunk against expData; bp applies the 1,0,0,1 ready pattern.
    task automatic drain(input int chunk, input bit bp, input int wantBubbles);
        int bubbles = 0;
        int beats = 0;
        int cyc = 0;
        bit holding = 1'b0;
        logic [63:0] held = '0;
        logic [3:0] pat = 4'b1001;
        while (!chunkValid && bubbles < 64) begin
            @(negedge pcieClk);
            bubbles++;
        end
        check($sformatf("c%0d_bubbles", chunk), 64'(bubbles), 64'(wantBubbles));
        while (beats < 16 && cyc < 200) begin
            chunkReady = bp ? pat[cyc % 4] : 1'b1;
            check($sformatf("c%0d_valid", chunk), 64'(chunkValid), 64'd1);
            check($sformatf("c%0d_rdChunk", chunk), 64'(rdChunk), 64'(chunk));
            if (holding)
                check($sformatf("c%0d_stall_stable", chunk), chunkData, held);
            if (chunkValid && chunkReady) begin
                check($sformatf("c%0d_beat%0d_data", chunk, beats), chunkData, expData[beats]);
                check($sformatf("c%0d_beat%0d_last", chunk, beats), 64'(chunkLast), 64'(beats == 15));
                beats++;
                holding = 1'b0;
            end else begin
                held    = chunkData;
                holding = chunkValid;
            end
            cyc++;
            @(negedge pcieClk);
        end
        check($sformatf("c%0d_beat_count", chunk), 64'(beats), 64'd16);
    endtask

    initial begin
        int waitCnt;
        int order [4];
        order = '{3, 0, 1, 2};

        repeat (2) @(negedge pcieClk);
        check("rst_valid", 64'(chunkValid), 64'd0);
        check("rst_last", 64'(chunkLast), 64'd0);
        check("rst_rdChunk", 64'(rdChunk), 64'd0);
        check("rst_freeCount", 64'(freeCount), 64'd4);
`ifdef C2F_SINK_OVERFLOW_EN
        check("rst_overflow", 64'(overflowErr), 64'd0);
`endif
        pcieRstN = 1'b1;
        @(negedge pcieClk);

        // Basic chunk 0, data = offset, ready held high.
        for (int i = 0; i < 16; i++) begin
            writeQw(0, i, 64'(i), 8'hFF);
            expData[i] = 64'(i);
        end
        check("a_freeCount_full", 64'(freeCount), 64'd3);
        check("a_valid_early", 64'(chunkValid), 64'd0);
        drain(0, 1'b0, 2);
        check("a_valid_after", 64'(chunkValid), 64'd0);
        check("a_rdChunk_after", 64'(rdChunk), 64'd1);
        check("a_freeCount_after", 64'(freeCount), 64'd4);

        // Chunk 1: partial byte-enable merge, streamed with backpressure.
        writeQw(1, 3, 64'h1111_1111_1111_1111, 8'hFF);
        for (int i = 0; i < 16; i++) begin
            if (i == 3)
                writeQw(1, 3, 64'h0000_0000_AAAA_AAAA, 8'h0F);
            else
                writeQw(1, i, 64'h100 + 64'(i), 8'hFF);
            expData[i] = 64'h100 + 64'(i);
        end
        expData[3] = 64'h1111_1111_AAAA_AAAA;
        drain(1, 1'b1, 2);
        check("b_rdChunk_after", 64'(rdChunk), 64'd2);
        check("b_freeCount_after", 64'(freeCount), 64'd4);

        // Chunk 2: reset asserted while beat 7 is presented.
        chunkReady = 1'b1;
        for (int i = 0; i < 16; i++)
            writeQw(2, i, 64'h200 + 64'(i), 8'hFF);
        waitCnt = 0;
        while (!chunkValid && waitCnt < 64) begin
            @(negedge pcieClk);
            waitCnt++;
        end
        check("d_valid_seen", 64'(chunkValid), 64'd1);
        repeat (7) @(negedge pcieClk);
        check("d_beat7_data", chunkData, 64'h207);
        #1 pcieRstN = 1'b0;
        #1;
        check("d_rst_valid", 64'(chunkValid), 64'd0);
        check("d_rst_last", 64'(chunkLast), 64'd0);
        check("d_rst_rdChunk", 64'(rdChunk), 64'd0);
        check("d_rst_freeCount", 64'(freeCount), 64'd4);
`ifdef C2F_SINK_OVERFLOW_EN
        check("d_rst_overflow", 64'(overflowErr), 64'd0);
`endif
        repeat (2) @(negedge pcieClk);
        pcieRstN = 1'b1;
        @(negedge pcieClk);

        // Out-of-order fill 3,0,1,2 with the consumer stalled, then drain in order.
        chunkReady = 1'b0;
        for (int off = 0; off < 16; off++)
            for (int k = 0; k < 4; k++)
                writeQw(order[k], off, 64'hC000 + 64'(order[k] * 256 + off), 8'hFF);
        check("c_freeCount_zero", 64'(freeCount), 64'd0);
        check("c_rdChunk_start", 64'(rdChunk), 64'd0);
`ifdef C2F_SINK_OVERFLOW_EN
        check("c_overflow_before", 64'(overflowErr), 64'd0);
`endif
        writeQw(1, 0, 64'hDEAD, 8'hFF);
`ifdef C2F_SINK_OVERFLOW_EN
        check("c_overflow_set", 64'(overflowErr), 64'd1);
`endif
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 16; i++)
                expData[i] = 64'hC000 + 64'(c * 256 + i);
            if (c == 1)
                expData[0] = 64'hDEAD;
            drain(c, 1'b0, (c == 0) ? 0 : 1);
        end
        check("c_valid_after", 64'(chunkValid), 64'd0);
        check("c_rdChunk_wrap", 64'(rdChunk), 64'd0);
        check("c_freeCount_after", 64'(freeCount), 64'd4);
`ifdef C2F_SINK_OVERFLOW_EN
        check("c_overflow_sticky", 64'(overflowErr), 64'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
